// File: rtl/nrisc_ula_pkg.sv
// nrisc ULA shared definitions.
// Opcode encodings and flag bit positions.
package nrisc_ula_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SHR = 4'b0101;
  localparam logic [3:0] OP_SHL = 4'b0110;
  localparam logic [3:0] OP_NOT = 4'b0111;
  localparam logic [3:0] OP_RTR = 4'b1101;
  localparam logic [3:0] OP_RTL = 4'b1110;

  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

  typedef logic [2:0] flags_t;

endpackage

// File: rtl/nrisc_ula_core.sv
// nrisc ULA combinational datapath.
// Produces result, {N,Z,C} flags and illegal-opcode error.
module nrisc_ula_core
  import nrisc_ula_pkg::*;
#(
  parameter int TAM = 16
) (
  input  logic [3:0]     ctrl,
  input  logic [TAM-1:0] a,
  input  logic [TAM-1:0] b,
  input  logic           incdec,
  output logic [TAM-1:0] out,
  output flags_t         flags,
  output logic           err
);

  logic [TAM-1:0] opb;
  logic [TAM:0]   sum_s;
  logic [TAM:0]   dif_s;
  logic [TAM:0]   sum_u;
  logic           borrow;
  logic           n;
  logic           c;

  // incdec only matters for ADD/SUB, the only users of opb
  assign opb    = incdec ? TAM'(1) : b;
  assign sum_s  = {a[TAM-1], a} + {opb[TAM-1], opb};
  assign dif_s  = {a[TAM-1], a} - {opb[TAM-1], opb};
  assign sum_u  = {1'b0, a} + {1'b0, opb};
  assign borrow = a < opb;

  // opcode decode and result/flag selection
  always_comb begin
    out = '0;
    n   = 1'b0;
    c   = 1'b0;
    err = 1'b0;
    unique case (ctrl)
      OP_ADD: begin
        out = sum_s[TAM-1:0];
        n   = sum_s[TAM];
        c   = sum_u[TAM];
      end
      OP_SUB: begin
        out = dif_s[TAM-1:0];
        n   = dif_s[TAM];
        c   = borrow;
      end
      OP_AND: out = a & b;
      OP_OR:  out = a | b;
      OP_XOR: out = a ^ b;
      OP_SHR: begin
        out = {a[TAM-1], a[TAM-1:1]};
        c   = a[0];
      end
      OP_RTR: out = {a[0], a[TAM-1:1]};
      OP_SHL: begin
        out = {a[TAM-2:0], 1'b0};
        c   = a[TAM-1];
      end
      OP_RTL: out = {a[TAM-2:0], a[TAM-1]};
      OP_NOT: out = ~a;
      default: err = 1'b1;
    endcase
  end

  // Z is suppressed for illegal opcodes so their flags stay 000
  always_comb begin
    flags         = '0;
    flags[FLAG_N] = n;
    flags[FLAG_Z] = (out == '0) && !err;
    flags[FLAG_C] = c;
  end

endmodule

// File: rtl/nrisc_ula_unit.sv
// nrisc ULA unit: compute core plus 2-entry response FIFO.
// flags_q tracks flags of accepted non-error responses.
module nrisc_ula_unit
  import nrisc_ula_pkg::*;
#(
  parameter int TAM = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [3:0]     req_ctrl,
  input  logic [TAM-1:0] req_a,
  input  logic [TAM-1:0] req_b,
  input  logic           req_incdec,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [TAM-1:0] rsp_out,
  output logic [2:0]     rsp_flags,
  output logic           rsp_err,
  output logic [2:0]     flags_q
);

  logic [TAM-1:0] c_out;
  flags_t         c_flags;
  logic           c_err;

  logic [TAM-1:0] mem_out   [2];
  flags_t         mem_flags [2];
  logic           mem_err   [2];
  logic           wr_ptr;
  logic           rd_ptr;
  logic [1:0]     count;
  logic           push;
  logic           pop;

  nrisc_ula_core #(
    .TAM (TAM)
  ) u_core (
    .ctrl   (req_ctrl),
    .a      (req_a),
    .b      (req_b),
    .incdec (req_incdec),
    .out    (c_out),
    .flags  (c_flags),
    .err    (c_err)
  );

  assign req_ready = count < 2'd2;
  assign rsp_valid = count != 2'd0;
  assign push      = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;

  assign rsp_out   = rsp_valid ? mem_out[rd_ptr]   : '0;
  assign rsp_flags = rsp_valid ? mem_flags[rd_ptr] : '0;
  assign rsp_err   = rsp_valid && mem_err[rd_ptr];

  // FIFO storage; contents are don't-care while count says empty
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_out[wr_ptr]   <= c_out;
      mem_flags[wr_ptr] <= c_flags;
      mem_err[wr_ptr]   <= c_err;
    end
  end

  // pointers, occupancy and architectural flag register
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
      flags_q <= 3'b000;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        if (!mem_err[rd_ptr]) flags_q <= mem_flags[rd_ptr];
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_nrisc_ula_unit.sv
// Directed self-checking bench for nrisc_ula_unit.
// Operand width 4, hand-computed expected values.
module tb_nrisc_ula_unit;

  localparam int TAM = 4;

  logic           clk;
  logic           rst;
  logic           req_valid;
  logic           req_ready;
  logic [3:0]     req_ctrl;
  logic [TAM-1:0] req_a;
  logic [TAM-1:0] req_b;
  logic           req_incdec;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [TAM-1:0] rsp_out;
  logic [2:0]     rsp_flags;
  logic           rsp_err;
  logic [2:0]     flags_q;

  int n_cmp;
  int n_bad;

  nrisc_ula_unit #(
    .TAM (TAM)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_ctrl   (req_ctrl),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_incdec (req_incdec),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_out    (rsp_out),
    .rsp_flags  (rsp_flags),
    .rsp_err    (rsp_err),
    .flags_q    (flags_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [3:0] op,
                         input logic [3:0] a,
                         input logic [3:0] b,
                         input logic inc);
    req_valid  = 1'b1;
    req_ctrl   = op;
    req_a      = a;
    req_b      = b;
    req_incdec = inc;
  endtask

  // one request, inspect head, pop, inspect flags_q
  task automatic do_op(input string tag,
                       input logic [3:0] op,
                       input logic [3:0] a,
                       input logic [3:0] b,
                       input logic inc,
                       input logic [3:0] e_out,
                       input logic [2:0] e_flg,
                       input logic [2:0] mask,
                       input logic e_err,
                       input logic [2:0] e_fq);
    rsp_ready = 1'b0;
    set_req(op, a, b, inc);
    tick();
    req_valid = 1'b0;
    chk({tag, ".valid"}, 16'(rsp_valid), 16'd1);
    chk({tag, ".out"}, 16'(rsp_out), 16'(e_out));
    chk({tag, ".flags"}, 16'(rsp_flags & mask), 16'(e_flg));
    chk({tag, ".err"}, 16'(rsp_err), 16'(e_err));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, ".empty"}, 16'(rsp_valid), 16'd0);
    chk({tag, ".fq"}, 16'(flags_q & mask), 16'(e_fq));
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_ctrl   = 4'd0;
    req_a      = 4'd0;
    req_b      = 4'd0;
    req_incdec = 1'b0;
    rsp_ready  = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst.valid", 16'(rsp_valid), 16'd0);
    chk("rst.ready", 16'(req_ready), 16'd1);
    chk("rst.fq", 16'(flags_q), 16'd0);
    chk("rst.out", 16'(rsp_out), 16'd0);
    chk("rst.err", 16'(rsp_err), 16'd0);

    //      tag      op       a        b        inc  out      flg     mask    err  fq
    do_op("add7p1", 4'b0000, 4'b0111, 4'b0001, 0, 4'b1000, 3'b000, 3'b111, 0, 3'b000);
    do_op("sub1m2", 4'b0001, 4'b0001, 4'b0010, 0, 4'b1111, 3'b101, 3'b111, 0, 3'b101);
    do_op("sub3m3", 4'b0001, 4'b0011, 4'b0011, 0, 4'b0000, 3'b010, 3'b111, 0, 3'b010);
    do_op("incF",   4'b0000, 4'b1111, 4'b0101, 1, 4'b0000, 3'b011, 3'b111, 0, 3'b011);
    do_op("and",    4'b0010, 4'b1100, 4'b1010, 1, 4'b1000, 3'b000, 3'b111, 0, 3'b000);
    do_op("or",     4'b0011, 4'b0101, 4'b1010, 0, 4'b1111, 3'b000, 3'b111, 0, 3'b000);
    do_op("xor",    4'b0100, 4'b1111, 4'b1111, 0, 4'b0000, 3'b010, 3'b111, 0, 3'b010);
    do_op("ill15",  4'b1111, 4'b0011, 4'b0011, 0, 4'b0000, 3'b000, 3'b111, 1, 3'b010);
    do_op("shr",    4'b0101, 4'b1001, 4'b0000, 0, 4'b1100, 3'b001, 3'b011, 0, 3'b001);
    do_op("shl",    4'b0110, 4'b1001, 4'b0000, 0, 4'b0010, 3'b001, 3'b011, 0, 3'b001);
    do_op("rtr",    4'b1101, 4'b1001, 4'b0000, 0, 4'b1100, 3'b000, 3'b111, 0, 3'b000);
    do_op("rtl",    4'b1110, 4'b1001, 4'b0000, 0, 4'b0011, 3'b000, 3'b111, 0, 3'b000);
    do_op("notA",   4'b0111, 4'b1010, 4'b0000, 0, 4'b0101, 3'b000, 3'b111, 0, 3'b000);
    do_op("notF",   4'b0111, 4'b1111, 4'b0000, 0, 4'b0000, 3'b010, 3'b111, 0, 3'b010);
    do_op("dec0",   4'b0001, 4'b0000, 4'b0111, 1, 4'b1111, 3'b101, 3'b111, 0, 3'b101);
    do_op("ill8",   4'b1000, 4'b0001, 4'b0001, 0, 4'b0000, 3'b000, 3'b111, 1, 3'b101);
    do_op("add77",  4'b0000, 4'b0111, 4'b0111, 0, 4'b1110, 3'b000, 3'b111, 0, 3'b000);
    do_op("add88",  4'b0000, 4'b1000, 4'b1000, 0, 4'b0000, 3'b111, 3'b111, 0, 3'b111);

    // backpressure: three back-to-back requests, consumer stalled
    rsp_ready = 1'b0;
    set_req(4'b0000, 4'd1, 4'd1, 1'b0);
    tick();
    chk("bp.rdy1", 16'(req_ready), 16'd1);
    set_req(4'b0000, 4'd2, 4'd1, 1'b0);
    tick();
    chk("bp.rdy2", 16'(req_ready), 16'd0);
    chk("bp.head1", 16'(rsp_out), 16'd2);
    set_req(4'b0000, 4'd3, 4'd1, 1'b0);
    tick();
    chk("bp.stall", 16'(req_ready), 16'd0);
    chk("bp.hold", 16'(rsp_out), 16'd2);
    rsp_ready = 1'b1;
    tick();
    chk("bp.pop1rdy", 16'(req_ready), 16'd1);
    chk("bp.head2", 16'(rsp_out), 16'd3);
    tick();
    req_valid = 1'b0;
    chk("bp.pushpop", 16'(rsp_valid), 16'd1);
    chk("bp.head3", 16'(rsp_out), 16'd4);
    chk("bp.rdy3", 16'(req_ready), 16'd1);
    tick();
    rsp_ready = 1'b0;
    chk("bp.drain", 16'(rsp_valid), 16'd0);

    // reset with a full FIFO and both handshakes active
    do_op("presub", 4'b0001, 4'b0001, 4'b0010, 0, 4'b1111, 3'b101, 3'b111, 0, 3'b101);
    set_req(4'b0000, 4'd5, 4'd1, 1'b0);
    tick();
    tick();
    chk("full.rdy", 16'(req_ready), 16'd0);
    rst       = 1'b1;
    rsp_ready = 1'b1;
    tick();
    rst       = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    chk("rst2.valid", 16'(rsp_valid), 16'd0);
    chk("rst2.ready", 16'(req_ready), 16'd1);
    chk("rst2.fq", 16'(flags_q), 16'd0);
    chk("rst2.out", 16'(rsp_out), 16'd0);
    tick();
    chk("rst2.stay", 16'(rsp_valid), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nrisc_ula_unit.md
NRISC_ULA_UNIT -- requirements
Module: nrisc_ula_unit

Interface
REQ-001 SHALL have parameter TAM, default 16; operand and result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port req_valid  input  1  request present.
REQ-005 SHALL have port req_ready  output  1  unit can accept a request this cycle.
REQ-006 SHALL have port req_ctrl  input  4  opcode, ULA encoding.
REQ-007 SHALL have port req_a  input  TAM  operand A, signed.
REQ-008 SHALL have port req_b  input  TAM  operand B, signed.
REQ-009 SHALL have port req_incdec  input  1  increment/decrement mode for ADD/SUB.
REQ-010 SHALL have port rsp_valid  output  1  response present.
REQ-011 SHALL have port rsp_ready  input  1  consumer accepts the response.
REQ-012 SHALL have port rsp_out  output  TAM  result.
REQ-013 SHALL have port rsp_flags  output  3  {N,Z,C}; bit2=N, bit1=Z, bit0=C.
REQ-014 SHALL have port rsp_err  output  1  illegal opcode.
REQ-015 SHALL have port flags_q  output  3  architectural flag register.

Function
REQ-016 Request SHALL be accepted on a rising edge with req_valid=1 and req_ready=1; response SHALL be accepted on a rising edge with rsp_valid=1 and rsp_ready=1.
REQ-017 Responses SHALL be held in a 2-entry in-order FIFO; req_ready SHALL equal (count<2) and SHALL have no combinational path from rsp_ready.
REQ-018 Latency: a request accepted at edge N SHALL appear at the FIFO head, with rsp_valid=1, from edge N+1 when the FIFO was empty.
REQ-019 Simultaneous push and pop SHALL keep count unchanged; a push while full SHALL be impossible by REQ-017.
REQ-020 Opcodes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SHR (arithmetic, 1 bit), 1101 RTR, 0110 SHL (logical, 1 bit), 1110 RTL, 0111 NOT (~A).
REQ-021 If req_incdec=1 and the opcode is ADD/SUB, B SHALL be replaced by 1; otherwise req_incdec SHALL be ignored.
REQ-022 Z SHALL be 1 iff rsp_out==0, for every legal opcode.
REQ-023 ADD: N = sign of the exact (TAM+1)-bit signed sum; C = unsigned carry-out of bit TAM-1.
REQ-024 SUB: N = sign of the exact (TAM+1)-bit signed difference; C = unsigned borrow (A<B unsigned).
REQ-025 SHR: C=A[0]. SHL: C=A[TAM-1]. All other legal opcodes: N=0, C=0.
REQ-026 Illegal opcodes (1000-1100, 1111) SHALL produce rsp_out=0, rsp_flags=000, rsp_err=1; legal opcodes SHALL produce rsp_err=0.
REQ-027 flags_q SHALL load the head entry's rsp_flags on each response accept where rsp_err=0, and SHALL otherwise hold.
REQ-028 rsp_out, rsp_flags and rsp_err SHALL be 0 whenever rsp_valid=0.

Reset
REQ-029 rst=1 at a rising edge SHALL empty the FIFO and clear flags_q to 000, so that rsp_valid=0 and req_ready=1 after that edge.
REQ-030 Requests or responses in flight during reset SHALL be discarded without effect, including any simultaneous handshake.

Structure
REQ-031 Opcode localparams and flag bit indices SHALL reside in the shared package nrisc_ula_pkg.
REQ-032 Combinational compute SHALL be one sub-module, nrisc_ula_core (operands, ctrl, incdec -> out, flags, err); the FIFO and flag register SHALL reside in nrisc_ula_unit.

Verification (TAM=4)
REQ-033 ADD A=0111, B=0001, rsp_ready=1 -> next cycle rsp_out=1000, rsp_flags=000, flags_q=000 after accept.
REQ-034 SUB A=0001, B=0010 -> rsp_out=1111, rsp_flags=101; SUB A=0011, B=0011 -> 0000, rsp_flags=010.
REQ-035 ADD with incdec=1, A=1111, B=0101 -> rsp_out=0000, rsp_flags=011 (N=0, Z=1, C=1).
REQ-036 rsp_ready=0 with three back-to-back valid requests -> two accepted, then req_ready=0; after rsp_ready=1, responses emerge in order and the third request is accepted the cycle after the first pop.
REQ-037 Opcode 1111 -> rsp_err=1, rsp_out=0000, rsp_flags=000, flags_q unchanged; SHR A=1001 -> 1100, C=1.
REQ-038 rst=1 with a full FIFO -> next cycle rsp_valid=0, req_ready=1, flags_q=000.
